// File: rtl/nbr_move_planner.sv
// nbr_move_planner: fetches the 3x3 board window around the ball and picks the best legal move direction.
// The window is read slot by slot from board RAM, then the eight directions are scored one per cycle.
module nbr_move_planner #(
    parameter int COORD_W    = 8,
    parameter int ADDR_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int GOAL_BONUS = 2,
    parameter int SCORE_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               my_turn,
    input  logic               abort,
    input  logic [COORD_W-1:0] current_x_in,
    input  logic [COORD_W-1:0] current_y_in,
    input  logic [COORD_W-1:0] width_in,
    input  logic [COORD_W-1:0] length_in,
    input  logic               color_in,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_data,
    output logic               idle,
    output logic [2:0]         direction,
    output logic               direction_valid,
    output logic               no_move,
    output logic               extra_turn,
    output logic [SCORE_W-1:0] best_score
);
    typedef enum logic [1:0] {IDLE, FETCH, SCORE, DONE} state_t;
    localparam int CW = $clog2(MEM_LAT + 11);

    state_t state;
    logic [CW-1:0] cnt;
    logic [COORD_W-1:0] cx, cy, w, l;
    logic col;
    logic [8:0][7:0] win;
    logic [8:0] oob;
    logic [MEM_LAT:0] pv;
    logic [MEM_LAT:0][3:0] ps;
    logic found, bx;
    logic [2:0] bd;
    logic [SCORE_W-1:0] bs;

    logic start, issue, inb, legal, goal, better;
    logic [3:0] ks, tk;
    logic [1:0] kx, ky;
    logic [2:0] d;
    logic [COORD_W-1:0] sx, sy, sw, sl;
    logic [COORD_W+1:0] nx, ny;
    logic [ADDR_W-1:0] addr;
    logic [SCORE_W-1:0] sc;

    assign idle = (state == IDLE);

    // Slot 0 is issued on the start edge itself, straight from the unlatched inputs.
    always_comb begin
        start = (state == IDLE) && my_turn;
        issue = start || (state == FETCH && cnt < CW'(9));
        ks = start ? 4'd0 : cnt[3:0];
        kx = 2'(ks % 4'd3);
        ky = 2'(ks / 4'd3);
        sx = start ? current_x_in : cx;
        sy = start ? current_y_in : cy;
        sw = start ? width_in : w;
        sl = start ? length_in : l;
        nx = {2'b0, sx} + (COORD_W+2)'(kx) - (COORD_W+2)'(1);
        ny = {2'b0, sy} + (COORD_W+2)'(ky) - (COORD_W+2)'(1);
        inb = !nx[COORD_W+1] && nx[COORD_W:0] < {1'b0, sw} && !ny[COORD_W+1] && ny[COORD_W:0] < {1'b0, sl};
        addr = ADDR_W'(ny[COORD_W-1:0]) * ADDR_W'(sw) + ADDR_W'(nx[COORD_W-1:0]);
        d = cnt[2:0];
        tk = d == 3'd0 ? 4'd1 : d == 3'd1 ? 4'd2 : d == 3'd2 ? 4'd5 : d == 3'd3 ? 4'd8 :
             d == 3'd4 ? 4'd7 : d == 3'd5 ? 4'd6 : d == 3'd6 ? 4'd3 : 4'd0;
        legal = !win[4][d] && !oob[tk];
        goal = col ? (d >= 3'd3 && d <= 3'd5) : (d == 3'd7 || d <= 3'd1);
        sc = SCORE_W'($countones(win[tk])) + (goal ? SCORE_W'(GOAL_BONUS) : '0);
        better = legal && (!found || sc > bs);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state <= IDLE;
            cnt <= '0;
            mem_rd <= 1'b0;
            mem_addr <= '0;
            pv <= '0;
            found <= 1'b0;
            direction <= '0;
            direction_valid <= 1'b0;
            no_move <= 1'b0;
            extra_turn <= 1'b0;
            best_score <= '0;
        end else begin
            direction_valid <= 1'b0;
            no_move <= 1'b0;
            mem_rd <= issue && inb;
            pv <= {pv[MEM_LAT-1:0], issue && inb};
            ps <= {ps[MEM_LAT-1:0], ks};
            if (issue)
                mem_addr <= addr;
            if (pv[MEM_LAT])
                win[ps[MEM_LAT]] <= mem_data;
            if (start) begin
                cx <= current_x_in;
                cy <= current_y_in;
                w <= width_in;
                l <= length_in;
                col <= color_in;
                win <= '0;
                oob <= '0;
                cnt <= CW'(1);
                found <= 1'b0;
                direction <= '0;
                extra_turn <= 1'b0;
                best_score <= '0;
                state <= FETCH;
            end
            // Off-board neighbours become walls immediately; later writes for this slot never occur.
            if (issue && !inb) begin
                win[ks] <= '1;
                oob[ks] <= 1'b1;
            end
            if (state == FETCH) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(9 + MEM_LAT)) begin
                    cnt <= '0;
                    state <= SCORE;
                end
            end
            if (state == SCORE) begin
                if (better) begin
                    found <= 1'b1;
                    bd <= d;
                    bs <= sc;
                    bx <= win[tk] != '0;
                end
                cnt <= cnt + CW'(1);
                if (d == 3'd7)
                    state <= DONE;
            end
            if (state == DONE) begin
                direction_valid <= found;
                no_move <= !found;
                direction <= found ? bd : 3'd0;
                best_score <= found ? bs : '0;
                extra_turn <= found && bx;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_nbr_move_planner.sv
// tb_nbr_move_planner: runs MEM_LAT=1 and MEM_LAT=3 planners side by side against a board-level move model.
module tb_nbr_move_planner;
    logic clk = 0, rst_n = 0, my_turn = 0, abort = 0, color_in = 0;
    logic [7:0] current_x_in = 0, current_y_in = 0, width_in = 0, length_in = 0;
    logic rd1, rd3, idle1, idle3, dv1, dv3, nm1, nm3, et1, et3;
    logic [15:0] addr1, addr3;
    logic [7:0] md1, md3, a3, b3;
    logic [2:0] dir1, dir3;
    logic [4:0] bs1, bs3;
    logic [7:0] board [0:1023];
    int compared = 0, mismatched = 0;
    int nrd1 = 0, nrd3 = 0;
    int lat1, lat3, rdn1, rdn3;
    logic [10:0] r1, r3;
    logic gidle1, gidle3;

    always #5 clk = ~clk;

    nbr_move_planner #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .my_turn(my_turn), .abort(abort),
        .current_x_in(current_x_in), .current_y_in(current_y_in), .width_in(width_in), .length_in(length_in),
        .color_in(color_in), .mem_rd(rd1), .mem_addr(addr1), .mem_data(md1), .idle(idle1), .direction(dir1),
        .direction_valid(dv1), .no_move(nm1), .extra_turn(et1), .best_score(bs1));

    nbr_move_planner #(.MEM_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .my_turn(my_turn), .abort(abort),
        .current_x_in(current_x_in), .current_y_in(current_y_in), .width_in(width_in), .length_in(length_in),
        .color_in(color_in), .mem_rd(rd3), .mem_addr(addr3), .mem_data(md3), .idle(idle3), .direction(dir3),
        .direction_valid(dv3), .no_move(nm3), .extra_turn(et3), .best_score(bs3));

    // Board RAMs; data off a read slot is garbage so mistimed captures show up.
    always @(posedge clk) begin
        md1 <= rd1 ? board[addr1[9:0]] : 8'($urandom);
        a3 <= rd3 ? board[addr3[9:0]] : 8'($urandom);
        b3 <= a3;
        md3 <= b3;
        if (rd1) nrd1++;
        if (rd3) nrd3++;
    end

    task automatic clear_board();
        for (int i = 0; i < 1024; i++) board[i] = 8'h00;
    endtask

    // Expected result packed as {valid, no_move, dir, score, extra}.
    task automatic model(input int x, y, w, l, c, output logic [10:0] res, output int nrd);
        int dxt[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        int dyt[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
        logic [7:0] ctr, tb;
        logic found, ext;
        int best, bd, sc, nx, ny;
        ctr = board[y*w+x];
        found = 0; ext = 0; best = 0; bd = 0;
        for (int k = 0; k < 8; k++) begin
            nx = x + dxt[k];
            ny = y + dyt[k];
            if (nx < 0 || nx >= w || ny < 0 || ny >= l || ctr[k]) continue;
            tb = board[ny*w+nx];
            sc = $countones(tb) + (((c == 0) && (k == 7 || k <= 1)) || ((c == 1) && k >= 3 && k <= 5) ? 2 : 0);
            if (!found || sc > best) begin
                found = 1; best = sc; bd = k; ext = (tb != 0);
            end
        end
        res = found ? {1'b1, 1'b0, 3'(bd), 5'(best), ext} : {1'b0, 1'b1, 3'd0, 5'd0, 1'b0};
        nrd = 0;
        for (int j = -1; j <= 1; j++)
            for (int i = -1; i <= 1; i++)
                if (x + i >= 0 && x + i < w && y + j >= 0 && y + j < l) nrd++;
    endtask

    task automatic run(input int x, y, w, l, c);
        int s1, s3;
        @(negedge clk);
        current_x_in = 8'(x); current_y_in = 8'(y); width_in = 8'(w); length_in = 8'(l); color_in = c[0];
        my_turn = 1; s1 = nrd1; s3 = nrd3;
        @(negedge clk);
        my_turn = 0;
        current_x_in = 8'($urandom); current_y_in = 8'($urandom); width_in = 8'($urandom);
        length_in = 8'($urandom); color_in = 1'($urandom);
        lat1 = -1; lat3 = -1; r1 = 'x; r3 = 'x;
        for (int k = 1; k <= 60 && (lat1 < 0 || lat3 < 0); k++) begin
            @(negedge clk);
            if (lat1 < 0 && (dv1 || nm1)) begin lat1 = k; r1 = {dv1, nm1, dir1, bs1, et1}; gidle1 = idle1; end
            if (lat3 < 0 && (dv3 || nm3)) begin lat3 = k; r3 = {dv3, nm3, dir3, bs3, et3}; gidle3 = idle3; end
        end
        rdn1 = nrd1 - s1;
        rdn3 = nrd3 - s3;
    endtask

    task automatic test_reset();
        rst_n = 0; my_turn = 1;
        repeat (3) @(negedge clk);
        compared++;
        if ({idle1, rd1, dv1, nm1, dir1, bs1, et1} !== 13'b1_0_0_0_000_00000_0) begin
            mismatched++; $display("FAIL reset_u1 got=%b exp=%b", {idle1, rd1, dv1, nm1, dir1, bs1, et1}, 13'b1_0_0_0_000_00000_0);
        end
        compared++;
        if ({idle3, rd3, dv3, nm3, dir3, bs3, et3} !== 13'b1_0_0_0_000_00000_0) begin
            mismatched++; $display("FAIL reset_u3 got=%b exp=%b", {idle3, rd3, dv3, nm3, dir3, bs3, et3}, 13'b1_0_0_0_000_00000_0);
        end
        my_turn = 0; rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_open_board();
        clear_board();
        run(4, 6, 9, 13, 0);
        compared++; if (r1 !== {1'b1, 1'b0, 3'd0, 5'd2, 1'b0}) begin mismatched++; $display("FAIL open_c0_u1 got=%b exp=%b", r1, {1'b1, 1'b0, 3'd0, 5'd2, 1'b0}); end
        compared++; if (r3 !== {1'b1, 1'b0, 3'd0, 5'd2, 1'b0}) begin mismatched++; $display("FAIL open_c0_u3 got=%b exp=%b", r3, {1'b1, 1'b0, 3'd0, 5'd2, 1'b0}); end
        compared++; if (lat1 !== 19) begin mismatched++; $display("FAIL latency_u1 got=%0d exp=19", lat1); end
        compared++; if (lat3 !== 21) begin mismatched++; $display("FAIL latency_u3 got=%0d exp=21", lat3); end
        compared++; if (rdn1 !== 9) begin mismatched++; $display("FAIL reads_open got=%0d exp=9", rdn1); end
        run(4, 6, 9, 13, 1);
        compared++; if (r1 !== {1'b1, 1'b0, 3'd3, 5'd2, 1'b0}) begin mismatched++; $display("FAIL open_c1_u1 got=%b exp=%b", r1, {1'b1, 1'b0, 3'd3, 5'd2, 1'b0}); end
        compared++; if (r3 !== {1'b1, 1'b0, 3'd3, 5'd2, 1'b0}) begin mismatched++; $display("FAIL open_c1_u3 got=%b exp=%b", r3, {1'b1, 1'b0, 3'd3, 5'd2, 1'b0}); end
    endtask

    task automatic test_bounce();
        clear_board();
        board[6*9+4] = 8'h01;
        board[5*9+5] = 8'h0F;
        run(4, 6, 9, 13, 0);
        compared++; if (r1 !== {1'b1, 1'b0, 3'd1, 5'd6, 1'b1}) begin mismatched++; $display("FAIL bounce_u1 got=%b exp=%b", r1, {1'b1, 1'b0, 3'd1, 5'd6, 1'b1}); end
        compared++; if (r3 !== {1'b1, 1'b0, 3'd1, 5'd6, 1'b1}) begin mismatched++; $display("FAIL bounce_u3 got=%b exp=%b", r3, {1'b1, 1'b0, 3'd1, 5'd6, 1'b1}); end
    endtask

    task automatic test_corner();
        clear_board();
        run(0, 0, 9, 13, 0);
        compared++; if (r1 !== {1'b1, 1'b0, 3'd2, 5'd0, 1'b0}) begin mismatched++; $display("FAIL corner_u1 got=%b exp=%b", r1, {1'b1, 1'b0, 3'd2, 5'd0, 1'b0}); end
        compared++; if (r3 !== {1'b1, 1'b0, 3'd2, 5'd0, 1'b0}) begin mismatched++; $display("FAIL corner_u3 got=%b exp=%b", r3, {1'b1, 1'b0, 3'd2, 5'd0, 1'b0}); end
        compared++; if (rdn1 !== 4) begin mismatched++; $display("FAIL corner_reads_u1 got=%0d exp=4", rdn1); end
        compared++; if (rdn3 !== 4) begin mismatched++; $display("FAIL corner_reads_u3 got=%0d exp=4", rdn3); end
    endtask

    task automatic test_no_move();
        clear_board();
        board[6*9+4] = 8'hFF;
        run(4, 6, 9, 13, 0);
        compared++; if (r1 !== {1'b0, 1'b1, 3'd0, 5'd0, 1'b0}) begin mismatched++; $display("FAIL no_move_u1 got=%b exp=%b", r1, {1'b0, 1'b1, 3'd0, 5'd0, 1'b0}); end
        compared++; if (r3 !== {1'b0, 1'b1, 3'd0, 5'd0, 1'b0}) begin mismatched++; $display("FAIL no_move_u3 got=%b exp=%b", r3, {1'b0, 1'b1, 3'd0, 5'd0, 1'b0}); end
        compared++; if ({gidle1, gidle3} !== 2'b11) begin mismatched++; $display("FAIL no_move_idle got=%b exp=11", {gidle1, gidle3}); end
    endtask

    task automatic test_abort();
        logic [10:0] e;
        int n, pulses;
        for (int i = 0; i < 1024; i++) board[i] = 8'($urandom) & 8'($urandom);
        @(negedge clk);
        current_x_in = 8'd4; current_y_in = 8'd6; width_in = 8'd9; length_in = 8'd13; color_in = 0;
        my_turn = 1; abort = 1;
        @(negedge clk);
        compared++; if ({idle1, idle3, rd1, rd3} !== 4'b1100) begin mismatched++; $display("FAIL abort_over_start got=%b exp=1100", {idle1, idle3, rd1, rd3}); end
        abort = 0;
        @(negedge clk);
        my_turn = 0;
        repeat (3) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        compared++; if ({idle1, idle3, rd1, rd3} !== 4'b1100) begin mismatched++; $display("FAIL abort_fetch got=%b exp=1100", {idle1, idle3, rd1, rd3}); end
        pulses = 0;
        repeat (25) begin @(negedge clk); pulses += int'(dv1 | nm1 | dv3 | nm3); end
        compared++; if (pulses !== 0) begin mismatched++; $display("FAIL abort_no_pulse got=%0d exp=0", pulses); end
        @(negedge clk);
        current_x_in = 8'd4; current_y_in = 8'd6; my_turn = 1;
        repeat (4) @(negedge clk);
        abort = 1; my_turn = 0;
        @(negedge clk);
        abort = 0;
        run(2, 3, 9, 13, 1);
        model(2, 3, 9, 13, 1, e, n);
        compared++; if (r1 !== e) begin mismatched++; $display("FAIL after_abort_u1 got=%b exp=%b", r1, e); end
        compared++; if (r3 !== e) begin mismatched++; $display("FAIL after_abort_u3 got=%b exp=%b", r3, e); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        current_x_in = 8'd4; current_y_in = 8'd6; width_in = 8'd9; length_in = 8'd13; my_turn = 1;
        @(negedge clk);
        my_turn = 0;
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        compared++; if ({idle1, idle3, rd1, rd3} !== 4'b1100) begin mismatched++; $display("FAIL reset_mid got=%b exp=1100", {idle1, idle3, rd1, rd3}); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int p1[$], p3[$];
        logic [10:0] f1;
        clear_board();
        f1 = 'x;
        @(negedge clk);
        current_x_in = 8'd4; current_y_in = 8'd6; width_in = 8'd9; length_in = 8'd13; color_in = 0; my_turn = 1;
        for (int k = 0; k < 47; k++) begin
            @(negedge clk);
            if (dv1 || nm1) begin if (p1.size() == 0) f1 = {dv1, nm1, dir1, bs1, et1}; p1.push_back(k); end
            if (dv3 || nm3) p3.push_back(k);
        end
        my_turn = 0;
        compared++; if (p1.size() !== 2 || p1[0] !== 19 || p1[1] !== 39) begin mismatched++; $display("FAIL b2b_u1 got=%0d pulses exp=2 at 19,39", p1.size()); end
        compared++; if (p3.size() !== 2 || p3[0] !== 21 || p3[1] !== 43) begin mismatched++; $display("FAIL b2b_u3 got=%0d pulses exp=2 at 21,43", p3.size()); end
        compared++; if (f1 !== {1'b1, 1'b0, 3'd0, 5'd2, 1'b0}) begin mismatched++; $display("FAIL b2b_result got=%b exp=%b", f1, {1'b1, 1'b0, 3'd0, 5'd2, 1'b0}); end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_random();
        int w, l, x, y, c, n;
        logic [10:0] e;
        for (int it = 0; it < 24; it++) begin
            w = $urandom_range(3, 16); l = $urandom_range(3, 16);
            x = $urandom_range(0, w - 1); y = $urandom_range(0, l - 1);
            if (it % 4 == 1) x = (it % 8 == 1) ? 0 : w - 1;
            if (it % 4 == 2) y = (it % 8 == 2) ? 0 : l - 1;
            c = $urandom_range(0, 1);
            for (int i = 0; i < 1024; i++) board[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            board[y*w+x] = 8'($urandom) & 8'($urandom);
            model(x, y, w, l, c, e, n);
            run(x, y, w, l, c);
            compared++; if (r1 !== e) begin mismatched++; $display("FAIL rand%0d_u1 got=%b exp=%b", it, r1, e); end
            compared++; if (r3 !== e) begin mismatched++; $display("FAIL rand%0d_u3 got=%b exp=%b", it, r3, e); end
            compared++; if (rdn1 !== n || rdn3 !== n) begin mismatched++; $display("FAIL rand%0d_reads got=%0d/%0d exp=%0d", it, rdn1, rdn3, n); end
            compared++; if (lat1 !== 19 || lat3 !== 21) begin mismatched++; $display("FAIL rand%0d_latency got=%0d/%0d exp=19/21", it, lat1, lat3); end
        end
    endtask

    initial begin
        test_reset();
        test_open_board();
        test_bounce();
        test_corner();
        test_no_move();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
